fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage wrapped around the 64-bit PC register.
- Reads the current PC and drives the register's next-value and enable inputs.
- Issues in-order requests to instruction memory and buffers the returned 32-bit instructions, each tagged with its PC, for decode.
- Handles front-end redirects (branch/jump/trap) by flushing buffered and in-flight fetches.

Parameters:
- XLEN, 64, address/PC width
- RESET_PC, 64'h0, PC value loaded after reset
- DEPTH, 2, fetch-buffer entries, which is also the maximum number of outstanding requests (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc_in  in  XLEN  current PC (PC register output)
- pc_next  out  XLEN  next PC (PC register data input)
- pc_enable  out  1  PC register load enable
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_resp_valid  in  1  response valid; responses arrive in request order, one per accepted request, always accepted
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  flush and redirect
- redirect_target  in  XLEN  new PC
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts
- if_instr  out  32  instruction
- if_pc  out  XLEN  PC of if_instr

Behaviour:
- **States:** BOOT, RUN.
  - Reset asserted (async) → BOOT, buffer empty, discard count 0.
  - BOOT lasts exactly one cycle after reset deasserts: pc_next=RESET_PC, pc_enable=1, imem_req_valid=0. Then → RUN.
- **Reset values:** imem_req_valid=0, if_valid=0. pc_enable follows the BOOT rule above. Other outputs are don't-care while their valid is low.
- **Buffer:** circular, DEPTH entries {pc, instr, filled}, with three pointers: alloc, fill, read. occ = allocated entries.
- **Request (RUN):**
  - imem_req_valid = (occ + discard < DEPTH) && !redirect_valid.
  - imem_req_addr = pc_in.
  - imem_req_valid must not depend on imem_req_ready.
- **On acceptance** (imem_req_valid && imem_req_ready):
  - Allocate an entry at alloc with pc=pc_in, filled=0.
  - pc_next = pc_in+4 (wraps modulo 2^XLEN), pc_enable=1.
- **Otherwise** (no acceptance, no redirect): pc_enable=0.
- **Response:**
  - If discard>0: drop the word, discard−1.
  - Else: write the word into the entry at fill, set filled=1, advance fill.
  - A response with nothing outstanding is ignored.
- **Output to decode:**
  - if_valid = entry at read is allocated and filled.
  - if_instr/if_pc come from that entry.
  - Pop on if_valid && if_ready.
  - Minimum latency: a response in cycle N is presented in cycle N+1 (registered, no bypass).
- **Redirect** (RUN, redirect_valid=1) has priority over everything:
  - pc_next=redirect_target, pc_enable=1, imem_req_valid=0.
  - All entries invalidated, pointers reset, if_valid forced 0 that cycle (no pop).
  - discard ← discard + allocated-unfilled entries − (1 if a response arrives this cycle).
  - The first post-redirect request issues the next cycle with addr=redirect_target.
- **Redirect during BOOT:** ignored.
- **Full buffer:** when occ+discard=DEPTH there are no requests. A pop in cycle N frees a slot for issue in cycle N+1 (occupancy used for issue is the registered value).
- **Simultaneous accept+response+pop in one cycle:** all three take effect; occ updates by +1−1.
- **Reset mid-operation:** immediately empties the buffer and clears discard. Responses still in memory after reset are the system's responsibility (memory is reset too).

Decomposition:
- Shared package `fetch_pkg`:
  - INSTR_W=32
  - PC_INC=4
  - state encoding (BOOT, RUN)
  - fetch-entry struct {pc, instr, filled}
- One natural sub-module: `fetch_buffer` (circular buffer with alloc/fill/read pointers, occ, flush).
- FSM, request, discard and PC logic stay in `fetch_unit`.

Test Plan:
- **Reset/boot:** hold reset low 3 cycles with pc_in=64'h40, release → exactly one cycle pc_next=0, pc_enable=1. Next cycle (pc_in=0): imem_req_valid=1, addr=0.
- **Streaming:** imem_req_ready=1, memory returns 32'h00000013 one cycle after each request, if_ready=1 → if_pc sequence 0,4,8,12 with one instruction per cycle in steady state, pc_enable=1 each accept.
- **Backpressure:** if_ready=0, DEPTH=2 → exactly 2 requests (addr 0,4), then imem_req_valid=0. Raise if_ready → if_pc=0 popped, new request addr=8 the following cycle.
- **Redirect with in-flight:** two requests outstanding (0,4), redirect_valid to 64'h100 → next cycle addr=64'h100. The two stale responses are dropped (if_valid stays 0). The first if_pc seen is 64'h100.
- **Redirect coincident with response:** one outstanding, response and redirect in the same cycle → discard stays 0. The next response belongs to 64'h100.
- **PC wrap:** pc_in=64'hFFFF_FFFF_FFFF_FFFC accepted → pc_next=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and buffer entry type for the fetch stage
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_INC     = 4;
  localparam int ENTRY_PC_W = 64;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [INSTR_W-1:0]    instr;
    logic                  filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular fetch buffer with alloc/fill/read pointers and flush
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int XLEN  = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_alloc,
  input  logic [XLEN-1:0]    i_alloc_pc,
  input  logic               i_fill,
  input  logic [INSTR_W-1:0] i_fill_instr,
  input  logic               i_pop,
  output logic [CW-1:0]      o_occ,
  output logic [CW-1:0]      o_unfilled,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [XLEN-1:0]    o_pc
);

  // Pointers carry one wrap bit so full and empty are distinguishable by subtraction.
  logic [CW-1:0] r_alloc_ptr;
  logic [CW-1:0] r_fill_ptr;
  logic [CW-1:0] r_read_ptr;
  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  w_head;

  assign o_occ      = r_alloc_ptr - r_read_ptr;
  assign o_unfilled = r_alloc_ptr - r_fill_ptr;
  assign w_head     = r_mem[r_read_ptr[AW-1:0]];
  assign o_valid    = (o_occ != '0) && w_head.filled;
  assign o_instr    = w_head.instr;
  assign o_pc       = w_head.pc[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_read_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_read_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
    end else begin
      // Alloc targets a free slot and fill an allocated one, so they never collide.
      if (i_alloc) begin
        r_mem[r_alloc_ptr[AW-1:0]].pc     <= ENTRY_PC_W'(i_alloc_pc);
        r_mem[r_alloc_ptr[AW-1:0]].filled <= 1'b0;
        r_alloc_ptr                       <= r_alloc_ptr + CW'(1);
      end
      if (i_fill) begin
        r_mem[r_fill_ptr[AW-1:0]].instr  <= i_fill_instr;
        r_mem[r_fill_ptr[AW-1:0]].filled <= 1'b1;
        r_fill_ptr                       <= r_fill_ptr + CW'(1);
      end
      if (i_pop) r_read_ptr <= r_read_ptr + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC sequencing, in-order imem requests,
// response buffering and redirect flush with stale-response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    pc_in,
  output logic [XLEN-1:0]    pc_next,
  output logic               pc_enable,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_e r_state;
  logic [CW-1:0] r_discard;

  logic          w_run;
  logic          w_redirect;
  logic          w_accept;
  logic          w_fill;
  logic          w_drop;
  logic          w_pop;
  logic          w_buf_valid;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_unfilled;
  logic [CW-1:0] w_resp_credit;
  logic [CW:0]   w_inflight;

  assign w_run      = (r_state == ST_RUN);
  assign w_redirect = w_run && redirect_valid;
  assign w_inflight = {1'b0, w_occ} + {1'b0, r_discard};

  assign imem_req_valid = w_run && !redirect_valid && (w_inflight < DEPTH_W);
  assign imem_req_addr  = pc_in;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // Responses owed to flushed requests are swallowed before any new one is buffered.
  assign w_drop = w_run && imem_resp_valid && (r_discard != '0);
  assign w_fill = w_run && imem_resp_valid && !w_redirect
                  && (r_discard == '0) && (w_unfilled != '0);
  assign w_resp_credit = CW'(imem_resp_valid && ((r_discard != '0) || (w_unfilled != '0)));

  assign if_valid = w_run && !redirect_valid && w_buf_valid;
  assign w_pop    = if_valid && if_ready;

  always_comb begin
    pc_next   = pc_in + XLEN'(PC_INC);
    pc_enable = 1'b0;
    if (!w_run) begin
      pc_next   = RESET_PC;
      pc_enable = 1'b1;
    end else if (w_redirect) begin
      pc_next   = redirect_target;
      pc_enable = 1'b1;
    end else if (w_accept) begin
      pc_enable = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_BOOT;
      r_discard <= '0;
    end else begin
      r_state <= ST_RUN;
      if (w_redirect) r_discard <= r_discard + w_unfilled - w_resp_credit;
      else if (w_drop) r_discard <= r_discard - CW'(1);
    end
  end

  fetch_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk          (clk),
    .rst_n        (reset),
    .i_flush      (w_redirect),
    .i_alloc      (w_accept),
    .i_alloc_pc   (pc_in),
    .i_fill       (w_fill),
    .i_fill_instr (imem_resp_data),
    .i_pop        (w_pop),
    .o_occ        (w_occ),
    .o_unfilled   (w_unfilled),
    .o_valid      (w_buf_valid),
    .o_instr      (if_instr),
    .o_pc         (if_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with PC register and memory models
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] pc_in;
  logic [63:0] pc_next;
  logic        pc_enable;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  int          n_vec;
  int          n_miss;
  bit          auto_resp;
  logic [63:0] mem_q [$];
  logic [63:0] pop_pc [$];
  logic [31:0] pop_ins [$];
  logic [31:0] exp_ins [4];

  fetch_unit #(
    .XLEN     (64),
    .RESET_PC (64'h0),
    .DEPTH    (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .pc_next         (pc_next),
    .pc_enable       (pc_enable),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: addi x0,x0,imm with imm = low 12 address bits.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[11:0], 20'h00013};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample before the edge, then update PC register and memory after it.
  task automatic tick();
    logic        acc;
    logic [63:0] a;
    logic        en;
    logic [63:0] nx;
    logic        rs;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    en  = pc_enable;
    nx  = pc_next;
    rs  = reset;
    if (if_valid && if_ready) begin
      pop_pc.push_back(if_pc);
      pop_ins.push_back(if_instr);
    end
    if (acc) chk("pc_en_on_accept", 64'(en), 64'd1);
    @(posedge clk);
    #1;
    if (rs && en) pc_in = nx;
    if (acc) mem_q.push_back(a);
    if (auto_resp && mem_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input logic boot_redir);
    reset = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_pc_enable", 64'(pc_enable), 64'd1);
    mem_q.delete();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    pc_in           = 64'h40;
    repeat (3) tick();
    reset = 1'b1;
    if (boot_redir) begin
      redirect_valid  = 1'b1;
      redirect_target = 64'h200;
    end
    #1;
    chk("boot_pc_next", pc_next, 64'h0);
    chk("boot_pc_enable", 64'(pc_enable), 64'd1);
    chk("boot_req_valid", 64'(imem_req_valid), 64'd0);
    chk("boot_if_valid", 64'(if_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    pop_pc.delete();
    pop_ins.delete();
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    exp_ins[0] = 32'h00000013;
    exp_ins[1] = 32'h00400013;
    exp_ins[2] = 32'h00800013;
    exp_ins[3] = 32'h00C00013;
    reset           = 1'b1;
    pc_in           = 64'h40;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_target = 64'h0;
    if_ready        = 1'b0;
    auto_resp       = 1'b0;
    @(posedge clk);
    #2;

    // Boot and streaming
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    auto_resp      = 1'b1;
    do_reset(1'b0);
    chk("a_req_valid", 64'(imem_req_valid), 64'd1);
    chk("a_req_addr", imem_req_addr, 64'h0);
    chk("a_pc_next", pc_next, 64'h4);
    chk("a_pc_enable", 64'(pc_enable), 64'd1);
    for (int i = 0; i < 20; i++) if (pop_pc.size() < 4) tick();
    chk("a_pop_count", 64'(pop_pc.size() >= 4), 64'd1);
    if (pop_pc.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("a_if_pc", pop_pc[k], 64'(4 * k));
        chk("a_if_instr", 64'(pop_ins[k]), 64'(exp_ins[k]));
      end
    end

    // Backpressure with a full buffer
    if_ready = 1'b0;
    do_reset(1'b0);
    chk("b_req0_valid", 64'(imem_req_valid), 64'd1);
    chk("b_req0_addr", imem_req_addr, 64'h0);
    tick();
    chk("b_req1_valid", 64'(imem_req_valid), 64'd1);
    chk("b_req1_addr", imem_req_addr, 64'h4);
    tick();
    chk("b_full_req_valid", 64'(imem_req_valid), 64'd0);
    chk("b_full_pc_enable", 64'(pc_enable), 64'd0);
    chk("b_full_if_valid", 64'(if_valid), 64'd1);
    chk("b_full_if_pc", if_pc, 64'h0);
    tick();
    if_ready = 1'b1;
    #1;
    chk("b_pop_req_valid", 64'(imem_req_valid), 64'd0);
    chk("b_pop_if_pc", if_pc, 64'h0);
    chk("b_pop_if_instr", 64'(if_instr), 64'h00000013);
    tick();
    chk("b_req2_valid", 64'(imem_req_valid), 64'd1);
    chk("b_req2_addr", imem_req_addr, 64'h8);
    chk("b_next_if_pc", if_pc, 64'h4);

    // Redirect with two requests in flight
    auto_resp = 1'b0;
    do_reset(1'b0);
    chk("c_req0_addr", imem_req_addr, 64'h0);
    tick();
    auto_resp = 1'b1;
    chk("c_req1_addr", imem_req_addr, 64'h4);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 64'h100;
    #1;
    chk("c_redir_req_valid", 64'(imem_req_valid), 64'd0);
    chk("c_redir_pc_next", pc_next, 64'h100);
    chk("c_redir_pc_enable", 64'(pc_enable), 64'd1);
    chk("c_redir_if_valid", 64'(if_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("c_post_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c_post_req_addr", imem_req_addr, 64'h100);
    chk("c_stale1_if_valid", 64'(if_valid), 64'd0);
    tick();
    chk("c_stale2_if_valid", 64'(if_valid), 64'd0);
    tick();
    chk("c_first_if_valid", 64'(if_valid), 64'd1);
    chk("c_first_if_pc", if_pc, 64'h100);
    chk("c_first_if_instr", 64'(if_instr), 64'h10000013);

    // Redirect coincident with the only outstanding response
    auto_resp = 1'b1;
    do_reset(1'b0);
    chk("d_req0_addr", imem_req_addr, 64'h0);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 64'h100;
    #1;
    chk("d_redir_resp_valid", 64'(imem_resp_valid), 64'd1);
    chk("d_redir_pc_next", pc_next, 64'h100);
    chk("d_redir_if_valid", 64'(if_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("d_post_req_addr", imem_req_addr, 64'h100);
    tick();
    chk("d_wait_if_valid", 64'(if_valid), 64'd0);
    tick();
    chk("d_first_if_valid", 64'(if_valid), 64'd1);
    chk("d_first_if_pc", if_pc, 64'h100);

    // Redirect in BOOT is ignored; PC increment wraps
    do_reset(1'b1);
    chk("e_boot_redir_req_addr", imem_req_addr, 64'h0);
    pc_in = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    chk("e_wrap_req_valid", 64'(imem_req_valid), 64'd1);
    chk("e_wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("e_wrap_pc_next", pc_next, 64'h0);
    chk("e_wrap_pc_enable", 64'(pc_enable), 64'd1);
    tick();
    chk("e_after_wrap_addr", imem_req_addr, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
